// File: rtl/rf_pipe_pkg.sv
// Shared definitions for the miniCPU register file slice.
// Holds the write-back source select codes used by ID/WB and rf_pipe.
package rf_pipe_pkg;

    // Write-back source select codes (rf_wsel).
    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_DREM = 2'd1;
    localparam logic [1:0] WB_EXT  = 2'd2;
    localparam logic [1:0] WB_PC   = 2'd3;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-producer scoreboard: one bit per register plus a population count.
// Ports: clk_i/rst_i; issue_valid_i/issue_rd_i (ID issue); we_i/wr_i (WB);
//        rd1_i/rd2_i lookup indices -> pend1_o/pend2_o; busy_cnt_o count.
module rf_scoreboard
    import rf_pipe_pkg::*;
#(
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          issue_valid_i,
    input  logic [AW-1:0] issue_rd_i,
    input  logic          we_i,
    input  logic [AW-1:0] wr_i,
    input  logic [AW-1:0] rd1_i,
    input  logic [AW-1:0] rd2_i,
    output logic          pend1_o,
    output logic          pend2_o,
    output logic [AW:0]   busy_cnt_o
);

    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    logic [NREG-1:0] pend_q, pend_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            iss_hit, wb_hit;
    logic            set_new, clr_old;

    always_comb begin
        iss_hit = issue_valid_i && (issue_rd_i != '0);
        wb_hit  = we_i && (wr_i != '0);

        // Issue is applied after the clear so a same-register
        // issue + write-back leaves the newer producer pending.
        pend_d = pend_q;
        if (wb_hit)
            pend_d[wr_i] = 1'b0;
        if (iss_hit)
            pend_d[issue_rd_i] = 1'b1;
        pend_d[0] = 1'b0;

        set_new = iss_hit && !pend_q[issue_rd_i];
        clr_old = wb_hit && pend_q[wr_i]
                  && !(iss_hit && (issue_rd_i == wr_i));

        cnt_d = cnt_q;
        if (set_new && !clr_old)
            cnt_d = cnt_q + CNT_ONE;
        else if (clr_old && !set_new)
            cnt_d = cnt_q - CNT_ONE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pend1_o    = pend_q[rd1_i];
    assign pend2_o    = pend_q[rd2_i];
    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/rf_pipe.sv
// Register file for the pipelined miniCPU: 2 async reads, 1 write, WB mux,
// optional write-to-read bypass and a pending-producer scoreboard.
// Ports: clk/rst; rR1/rR2 -> rD1/rD2 + busy flags; issue_valid/issue_rd;
//        we/wR with from_* sources selected by rf_wsel -> wD; busy_cnt.
module rf_pipe
    import rf_pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AW     = $clog2(NREG),
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rR1,
    input  logic [AW-1:0]   rR2,
    output logic [XLEN-1:0] rD1,
    output logic [XLEN-1:0] rD2,
    output logic            rD1_busy,
    output logic            rD2_busy,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic            we,
    input  logic [AW-1:0]   wR,
    input  logic [XLEN-1:0] from_alu,
    input  logic [XLEN-1:0] from_dram,
    input  logic [XLEN-1:0] from_imm,
    input  logic [XLEN-1:0] from_pc4,
    input  logic [1:0]      rf_wsel,
    output logic [XLEN-1:0] wD,
    output logic [AW:0]     busy_cnt
);

    logic [XLEN-1:0] rf_q [NREG];
    logic            pend1, pend2;
    logic            byp1, byp2;

    always_comb begin
        case (rf_wsel)
            WB_ALU:  wD = from_alu;
            WB_DREM: wD = from_dram;
            WB_EXT:  wD = from_imm;
            WB_PC:   wD = from_pc4;
            default: wD = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++)
                rf_q[r] <= '0;
        end else if (we && (wR != '0)) begin
            rf_q[wR] <= wD;
        end
    end

    // Forward the in-flight write when it targets a read port.
    assign byp1 = (BYPASS != 0) && we && (wR == rR1);
    assign byp2 = (BYPASS != 0) && we && (wR == rR2);

    always_comb begin
        rD1 = '0;
        if (rR1 != '0)
            rD1 = byp1 ? wD : rf_q[rR1];
    end

    always_comb begin
        rD2 = '0;
        if (rR2 != '0)
            rD2 = byp2 ? wD : rf_q[rR2];
    end

    rf_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_sb (
        .clk_i         (clk),
        .rst_i         (rst),
        .issue_valid_i (issue_valid),
        .issue_rd_i    (issue_rd),
        .we_i          (we),
        .wr_i          (wR),
        .rd1_i         (rR1),
        .rd2_i         (rR2),
        .pend1_o       (pend1),
        .pend2_o       (pend2),
        .busy_cnt_o    (busy_cnt)
    );

    // A completing write resolves the hazard in the same cycle.
    assign rD1_busy = pend1 && !byp1;
    assign rD2_busy = pend2 && !byp2;

endmodule

// File: tb/tb_rf_pipe.sv
// Bench for rf_pipe: three configurations driven in lockstep.
// dut0 default, dut1 BYPASS=0, dut2 NREG=16/XLEN=64.
module tb_rf_pipe;

    logic        clk, rst, we, iv;
    logic [4:0]  wR, rR1, rR2, ird;
    logic [1:0]  sel;
    logic [63:0] alu, dram, imm, pc4;

    logic [31:0] d0_1, d0_2, d0_w, d1_1, d1_2, d1_w;
    logic [63:0] d2_1, d2_2, d2_w;
    logic        b0_1, b0_2, b1_1, b1_2, b2_1, b2_2;
    logic [5:0]  c0, c1;
    logic [4:0]  c2;

    int errors = 0;
    int checks = 0;

    rf_pipe u0 (
        .clk(clk), .rst(rst), .rR1(rR1), .rR2(rR2),
        .rD1(d0_1), .rD2(d0_2), .rD1_busy(b0_1), .rD2_busy(b0_2),
        .issue_valid(iv), .issue_rd(ird), .we(we), .wR(wR),
        .from_alu(alu[31:0]), .from_dram(dram[31:0]),
        .from_imm(imm[31:0]), .from_pc4(pc4[31:0]),
        .rf_wsel(sel), .wD(d0_w), .busy_cnt(c0)
    );

    rf_pipe #(.BYPASS(0)) u1 (
        .clk(clk), .rst(rst), .rR1(rR1), .rR2(rR2),
        .rD1(d1_1), .rD2(d1_2), .rD1_busy(b1_1), .rD2_busy(b1_2),
        .issue_valid(iv), .issue_rd(ird), .we(we), .wR(wR),
        .from_alu(alu[31:0]), .from_dram(dram[31:0]),
        .from_imm(imm[31:0]), .from_pc4(pc4[31:0]),
        .rf_wsel(sel), .wD(d1_w), .busy_cnt(c1)
    );

    rf_pipe #(.NREG(16), .XLEN(64)) u2 (
        .clk(clk), .rst(rst), .rR1(rR1[3:0]), .rR2(rR2[3:0]),
        .rD1(d2_1), .rD2(d2_2), .rD1_busy(b2_1), .rD2_busy(b2_2),
        .issue_valid(iv), .issue_rd(ird[3:0]), .we(we), .wR(wR[3:0]),
        .from_alu(alu), .from_dram(dram),
        .from_imm(imm), .from_pc4(pc4),
        .rf_wsel(sel), .wD(d2_w), .busy_cnt(c2)
    );

    logic [63:0] o_rd1 [3], o_rd2 [3], o_wd [3], o_cnt [3];
    logic        o_b1 [3], o_b2 [3];

    assign o_rd1[0] = {32'h0, d0_1};
    assign o_rd1[1] = {32'h0, d1_1};
    assign o_rd1[2] = d2_1;
    assign o_rd2[0] = {32'h0, d0_2};
    assign o_rd2[1] = {32'h0, d1_2};
    assign o_rd2[2] = d2_2;
    assign o_wd[0]  = {32'h0, d0_w};
    assign o_wd[1]  = {32'h0, d1_w};
    assign o_wd[2]  = d2_w;
    assign o_cnt[0] = {58'h0, c0};
    assign o_cnt[1] = {58'h0, c1};
    assign o_cnt[2] = {59'h0, c2};
    assign o_b1[0]  = b0_1;
    assign o_b1[1]  = b1_1;
    assign o_b1[2]  = b2_1;
    assign o_b2[0]  = b0_2;
    assign o_b2[1]  = b1_2;
    assign o_b2[2]  = b2_2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [63:0] m_rf [3][32];
    bit          m_pd [3][32];

    function automatic bit byp(int k);
        return k != 1;
    endfunction

    function automatic int ix(int k, logic [4:0] i);
        return (k == 2) ? int'(i[3:0]) : int'(i);
    endfunction

    function automatic logic [63:0] msk(int k, logic [63:0] v);
        return (k == 2) ? v : {32'h0, v[31:0]};
    endfunction

    function automatic logic [63:0] e_wd(int k);
        logic [63:0] v;
        case (sel)
            2'd0: v = alu;
            2'd1: v = dram;
            2'd2: v = imm;
            default: v = pc4;
        endcase
        return msk(k, v);
    endfunction

    function automatic logic [63:0] e_rd(int k, logic [4:0] rr);
        int r = ix(k, rr);
        if (r == 0) return 64'h0;
        if (byp(k) && we && ix(k, wR) == r) return e_wd(k);
        return m_rf[k][r];
    endfunction

    function automatic logic e_bz(int k, logic [4:0] rr);
        int r = ix(k, rr);
        return m_pd[k][r] && !(byp(k) && we && ix(k, wR) == r);
    endfunction

    function automatic logic [63:0] e_cnt(int k);
        int n = 0;
        for (int r = 0; r < 32; r++)
            if (m_pd[k][r]) n++;
        return 64'(n);
    endfunction

    task automatic m_edge();
        for (int k = 0; k < 3; k++) begin
            bit np [32];
            if (rst) begin
                for (int r = 0; r < 32; r++) begin
                    m_rf[k][r] = 64'h0;
                    m_pd[k][r] = 1'b0;
                end
            end else begin
                np[0] = 1'b0;
                for (int r = 1; r < 32; r++)
                    np[r] = (iv && ix(k, ird) == r)
                         || (m_pd[k][r] && !(we && ix(k, wR) == r));
                if (we && ix(k, wR) != 0)
                    m_rf[k][ix(k, wR)] = e_wd(k);
                for (int r = 0; r < 32; r++)
                    m_pd[k][r] = np[r];
            end
        end
    endtask

    task automatic chk(string nm, int k, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %h want %h", nm, k, act, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk("rD1", k, o_rd1[k], e_rd(k, rR1));
            chk("rD2", k, o_rd2[k], e_rd(k, rR2));
            chk("busy1", k, 64'(o_b1[k]), 64'(e_bz(k, rR1)));
            chk("busy2", k, 64'(o_b2[k]), 64'(e_bz(k, rR2)));
            chk("wD", k, o_wd[k], e_wd(k));
            chk("cnt", k, o_cnt[k], e_cnt(k));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        rst, we;
        logic [4:0]  wR;
        logic [1:0]  sel;
        logic [31:0] alu, dram, imm, pc4;
        logic [4:0]  rR1, rR2;
        logic        iv;
        logic [4:0]  ird;
        logic [31:0] eD1, eD2;
        logic        eB1, eB2;
        logic [5:0]  eC;
        logic [31:0] eW;
    } vec_t;

    function automatic vec_t mk(
        logic r, logic w, logic [4:0] wr, logic [1:0] s,
        logic [31:0] a, logic [31:0] d, logic [31:0] i, logic [31:0] p,
        logic [4:0] r1, logic [4:0] r2, logic v, logic [4:0] rd,
        logic [31:0] e1, logic [31:0] e2, logic eb1, logic eb2,
        logic [5:0] ec, logic [31:0] ew);
        vec_t t;
        t.rst = r; t.we = w; t.wR = wr; t.sel = s;
        t.alu = a; t.dram = d; t.imm = i; t.pc4 = p;
        t.rR1 = r1; t.rR2 = r2; t.iv = v; t.ird = rd;
        t.eD1 = e1; t.eD2 = e2; t.eB1 = eb1; t.eB2 = eb2;
        t.eC = ec; t.eW = ew;
        return t;
    endfunction

    vec_t tbl [18];

    task automatic apply(vec_t v);
        rst = v.rst; we = v.we; wR = v.wR; sel = v.sel;
        alu = {32'h0, v.alu}; dram = {32'h0, v.dram};
        imm = {32'h0, v.imm}; pc4 = {32'h0, v.pc4};
        rR1 = v.rR1; rR2 = v.rR2; iv = v.iv; ird = v.ird;
    endtask

    task automatic idle();
        rst = 0; we = 0; iv = 0; wR = 0; ird = 0; sel = 0;
        alu = 0; dram = 0; imm = 0; pc4 = 0; rR1 = 0; rR2 = 0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++)
            for (int r = 0; r < 32; r++) begin
                m_rf[k][r] = 64'h0;
                m_pd[k][r] = 1'b0;
            end
        idle();
        rst = 1;
        tick();

        //            rst we wR sel alu           dram  imm     pc4    rR1 rR2 iv ird  eD1           eD2           b1 b2 cnt eW
        tbl[0]  = mk(1, 0, 0, 0, 0,            0,    0,      0,      5, 31, 0, 0, 0,            0,            0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 3, 0, 32'hDEADBEEF, 0,    0,      0,      3, 0,  0, 0, 32'hDEADBEEF, 0,            0, 0, 0, 32'hDEADBEEF);
        tbl[2]  = mk(0, 0, 0, 0, 0,            0,    0,      0,      3, 0,  0, 0, 32'hDEADBEEF, 0,            0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 0, 2, 0,            0,    32'h1234, 0,    0, 3,  1, 0, 0,            32'hDEADBEEF, 0, 0, 0, 32'h1234);
        tbl[4]  = mk(0, 0, 0, 0, 0,            0,    0,      0,      0, 7,  1, 7, 0,            0,            0, 0, 0, 0);
        tbl[5]  = mk(0, 1, 7, 0, 32'hA5,       0,    0,      0,      0, 7,  1, 7, 0,            32'hA5,       0, 0, 1, 32'hA5);
        tbl[6]  = mk(0, 0, 0, 0, 0,            0,    0,      0,      0, 7,  0, 0, 0,            32'hA5,       0, 1, 1, 0);
        tbl[7]  = mk(0, 1, 7, 3, 0,            0,    0,      32'h77, 7, 7,  0, 0, 32'h77,       32'h77,       0, 0, 1, 32'h77);
        tbl[8]  = mk(0, 0, 0, 0, 0,            0,    0,      0,      7, 0,  0, 0, 32'h77,       0,            0, 0, 0, 0);
        tbl[9]  = mk(0, 1, 9, 1, 0,            32'h55, 0,    0,      9, 0,  1, 9, 32'h55,       0,            0, 0, 0, 32'h55);
        tbl[10] = mk(1, 1, 9, 3, 0,            0,    0,      32'h100, 9, 9, 0, 0, 32'h100,      32'h100,      0, 0, 1, 32'h100);
        tbl[11] = mk(0, 0, 0, 0, 0,            0,    0,      0,      9, 3,  0, 0, 0,            0,            0, 0, 0, 0);
        tbl[12] = mk(0, 1, 10, 0, 32'h11,      32'h22, 32'h33, 32'h44, 10, 0, 0, 0, 32'h11,    0,            0, 0, 0, 32'h11);
        tbl[13] = mk(0, 1, 11, 1, 32'h11,      32'h22, 32'h33, 32'h44, 11, 0, 0, 0, 32'h22,    0,            0, 0, 0, 32'h22);
        tbl[14] = mk(0, 1, 12, 2, 32'h11,      32'h22, 32'h33, 32'h44, 12, 0, 0, 0, 32'h33,    0,            0, 0, 0, 32'h33);
        tbl[15] = mk(0, 1, 13, 3, 32'h11,      32'h22, 32'h33, 32'h44, 13, 0, 0, 0, 32'h44,    0,            0, 0, 0, 32'h44);
        tbl[16] = mk(0, 0, 0, 0, 0,            0,    0,      0,      10, 11, 0, 0, 32'h11,     32'h22,       0, 0, 0, 0);
        tbl[17] = mk(0, 0, 0, 0, 0,            0,    0,      0,      12, 13, 0, 0, 32'h33,     32'h44,       0, 0, 0, 0);

        for (int i = 0; i < 18; i++) begin
            apply(tbl[i]);
            @(negedge clk);
            chk($sformatf("tbl%0d_rD1", i), 0, o_rd1[0], {32'h0, tbl[i].eD1});
            chk($sformatf("tbl%0d_rD2", i), 0, o_rd2[0], {32'h0, tbl[i].eD2});
            chk($sformatf("tbl%0d_b1", i), 0, 64'(o_b1[0]), 64'(tbl[i].eB1));
            chk($sformatf("tbl%0d_b2", i), 0, 64'(o_b2[0]), 64'(tbl[i].eB2));
            chk($sformatf("tbl%0d_cnt", i), 0, o_cnt[0], {58'h0, tbl[i].eC});
            chk($sformatf("tbl%0d_wD", i), 0, o_wd[0], {32'h0, tbl[i].eW});
            check_all();
            tick();
        end

        // No-bypass: same-cycle read returns the old value, busy persists.
        idle();
        we = 1; wR = 20; alu = 64'hCAFE; rR1 = 20;
        @(negedge clk);
        chk("nobyp_same", 1, o_rd1[1], 64'h0);
        chk("byp_same", 0, o_rd1[0], 64'hCAFE);
        check_all();
        tick();
        idle();
        rR1 = 20; iv = 1; ird = 21;
        @(negedge clk);
        chk("nobyp_next", 1, o_rd1[1], 64'hCAFE);
        check_all();
        tick();
        idle();
        we = 1; wR = 21; rR1 = 21;
        @(negedge clk);
        chk("nobyp_busy", 1, 64'(o_b1[1]), 64'h1);
        chk("byp_busy", 0, 64'(o_b1[0]), 64'h0);
        check_all();
        tick();
        idle();
        rR1 = 21;
        @(negedge clk);
        chk("busy_clr", 1, 64'(o_b1[1]), 64'h0);
        check_all();
        tick();

        // Randomised run against the model.
        for (int n = 0; n < 400; n++) begin
            rst  = ($urandom_range(0, 49) == 0);
            we   = $urandom_range(0, 1) == 1;
            iv   = $urandom_range(0, 99) < 60;
            wR   = 5'($urandom_range(0, 31));
            ird  = 5'($urandom_range(0, 31));
            rR1  = 5'($urandom_range(0, 31));
            rR2  = 5'($urandom_range(0, 31));
            sel  = 2'($urandom_range(0, 3));
            alu  = {$urandom, $urandom};
            dram = {$urandom, $urandom};
            imm  = {$urandom, $urandom};
            pc4  = {$urandom, $urandom};
            @(negedge clk);
            check_all();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
